// File: rtl/tlc_pkg.sv
// Shared state encoding, lamp bundle and default timing for the traffic light controller.
// TRAFFIC_LIGHT_NIGHT_EN adds the NIGHT state.
package tlc_pkg;

  localparam int unsigned DEF_TICK_DIV = 100000000;
  localparam int unsigned DEF_T_BASE   = 6;
  localparam int unsigned DEF_T_EXT    = 3;
  localparam int unsigned DEF_T_YEL    = 2;
  localparam int unsigned DEF_T_WALK   = 3;
  localparam int unsigned DEF_TW       = 4;

  typedef enum logic [2:0] {
    MAIN_G,
    MAIN_Y,
    WALK,
    SIDE_G,
    SIDE_Y
`ifdef TRAFFIC_LIGHT_NIGHT_EN
    , NIGHT
`endif
  } state_t;

  typedef struct packed {
    logic main_r;
    logic main_y;
    logic main_g;
    logic side_r;
    logic side_y;
    logic side_g;
    logic walk_lamp;
  } lamps_t;

endpackage

// File: rtl/tlc_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, realigned to zero by restart.
module tlc_tick_gen #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || restart || tick) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with pedestrian walk phase and one-shot green extension.
// Defining TRAFFIC_LIGHT_NIGHT_EN adds the night input and the flashing NIGHT state.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned T_BASE   = DEF_T_BASE,
  parameter int unsigned T_EXT    = DEF_T_EXT,
  parameter int unsigned T_YEL    = DEF_T_YEL,
  parameter int unsigned T_WALK   = DEF_T_WALK,
  parameter int unsigned TW       = DEF_TW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          walk,
  input  logic          sensor,
`ifdef TRAFFIC_LIGHT_NIGHT_EN
  input  logic          night,
`endif
  output logic          main_r,
  output logic          main_y,
  output logic          main_g,
  output logic          side_r,
  output logic          side_y,
  output logic          side_g,
  output logic          walk_lamp,
  output logic [TW-1:0] sec_left
);

  state_t        state, state_n;
  lamps_t        lamps, lamps_n;
  logic [TW-1:0] sec_n;
  logic          ext_flag, ext_n;
  logic          in_ext, in_ext_n;
  logic          walk_req, walk_req_n;
  logic          restart, tick, expire;

  tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  function automatic logic [TW-1:0] phase_len(input state_t s);
    case (s)
      MAIN_G, SIDE_G: phase_len = TW'(T_BASE);
      MAIN_Y, SIDE_Y: phase_len = TW'(T_YEL);
      WALK:           phase_len = TW'(T_WALK);
      default:        phase_len = '0;
    endcase
  endfunction

  always_comb begin
    state_n    = state;
    sec_n      = sec_left;
    ext_n      = ext_flag;
    in_ext_n   = in_ext;
    walk_req_n = walk_req | walk;
    restart    = 1'b0;
    expire     = tick && (sec_left == TW'(1));
    if (tick && (sec_left != '0)) sec_n = sec_left - TW'(1);

    case (state)
      MAIN_G, SIDE_G: begin
        // sensor on the expiry cycle itself still earns the extension
        if (!in_ext && sensor) ext_n = 1'b1;
        if (expire) begin
          if (!in_ext && (ext_flag || sensor)) begin
            sec_n    = TW'(T_EXT);
            in_ext_n = 1'b1;
            restart  = 1'b1;
          end else begin
            state_n = (state == MAIN_G) ? MAIN_Y : SIDE_Y;
          end
        end
      end
      MAIN_Y: if (expire) state_n = walk_req ? WALK : SIDE_G;
      WALK:   if (expire) state_n = SIDE_G;
      SIDE_Y: if (expire) state_n = MAIN_G;
`ifdef TRAFFIC_LIGHT_NIGHT_EN
      NIGHT: begin
        sec_n = '0;
        if (!night) state_n = MAIN_G;
      end
`endif
      default: state_n = MAIN_G;
    endcase

`ifdef TRAFFIC_LIGHT_NIGHT_EN
    if (night) state_n = NIGHT;
`endif

    if (state_n != state) begin
      restart  = 1'b1;
      ext_n    = 1'b0;
      in_ext_n = 1'b0;
      sec_n    = phase_len(state_n);
      if (state_n == WALK) walk_req_n = 1'b0;
    end
  end

  always_comb begin
    lamps_n = '0;
    case (state_n)
      MAIN_G: begin lamps_n.main_g = 1'b1; lamps_n.side_r = 1'b1; end
      MAIN_Y: begin lamps_n.main_y = 1'b1; lamps_n.side_r = 1'b1; end
      WALK: begin
        lamps_n.main_r    = 1'b1;
        lamps_n.side_r    = 1'b1;
        lamps_n.walk_lamp = 1'b1;
      end
      SIDE_G: begin lamps_n.main_r = 1'b1; lamps_n.side_g = 1'b1; end
      SIDE_Y: begin lamps_n.main_r = 1'b1; lamps_n.side_y = 1'b1; end
`ifdef TRAFFIC_LIGHT_NIGHT_EN
      NIGHT: begin
        if (state != NIGHT) begin
          lamps_n.main_y = 1'b1;
          lamps_n.side_r = 1'b1;
        end else begin
          lamps_n.main_y = lamps.main_y ^ tick;
          lamps_n.side_r = lamps.side_r ^ tick;
        end
      end
`endif
      default: begin lamps_n.main_g = 1'b1; lamps_n.side_r = 1'b1; end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= MAIN_G;
      sec_left <= TW'(T_BASE);
      ext_flag <= 1'b0;
      in_ext   <= 1'b0;
      walk_req <= 1'b0;
      lamps    <= '{main_g: 1'b1, side_r: 1'b1, default: 1'b0};
    end else begin
      state    <= state_n;
      sec_left <= sec_n;
      ext_flag <= ext_n;
      in_ext   <= in_ext_n;
      walk_req <= walk_req_n;
      lamps    <= lamps_n;
    end
  end

  assign main_r    = lamps.main_r;
  assign main_y    = lamps.main_y;
  assign main_g    = lamps.main_g;
  assign side_r    = lamps.side_r;
  assign side_y    = lamps.side_y;
  assign side_g    = lamps.side_g;
  assign walk_lamp = lamps.walk_lamp;

endmodule
